pixel_loader: RTL and testbench
===============================

PIXEL_LOADER -- requirements
Module: pixel_loader

Interface
REQ-001 The block SHALL have parameter Ncells, default 307200 (640*480), the number of 1-bit VRAM cells addressed.
REQ-002 The block SHALL have parameter Header, default 8'hA5, the frame-start byte value.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low (ports CLK and RST_).
REQ-004 The block SHALL have port CLK  input  1  rising-edge clock shared with UART and VRAM.
REQ-005 The block SHALL have port RST_  input  1  synchronous active-low reset.
REQ-006 The block SHALL have port DIN  input  8  received byte from the UART DOUT.
REQ-007 The block SHALL have port INT  input  1  one-cycle strobe; DIN is valid in that cycle.
REQ-008 The block SHALL have port ADDR  output  $clog2(Ncells)  VRAM write address.
REQ-009 The block SHALL have port WR  output  1  VRAM write enable, one pixel per cycle.
REQ-010 The block SHALL have port DOUT  output  1  pixel value written at ADDR when WR=1.
REQ-011 The block SHALL have port BUSY  output  1  high while a frame is in progress.
REQ-012 The block SHALL have port DONE  output  1  one-cycle pulse when a frame completes.
REQ-013 The block SHALL have port ERR  output  1  one-cycle pulse on an aborted frame.

Function
REQ-014 The frame format SHALL be: Header, A2, A1, A0 (24-bit big-endian start address, low $clog2(Ncells) bits used), L1, L0 (16-bit big-endian payload byte count N), then N payload bytes.
REQ-015 The parser states SHALL be IDLE, ADR2, ADR1, ADR0, LEN1, LEN0 and DATA; each advances only on a cycle with INT=1.
REQ-016 In IDLE, INT with DIN==Header SHALL go to ADR2 and set BUSY the next cycle; any other byte SHALL be ignored.
REQ-017 At LEN0, a full address >= Ncells SHALL pulse ERR for one cycle and return the block to IDLE with BUSY=0 and no writes.
REQ-018 At LEN0 with N==0, the block SHALL pulse DONE in the next cycle, return to IDLE and clear BUSY.
REQ-019 In DATA, the block SHALL accept each payload byte on INT into an 8-bit shifter when the shifter is idle, or otherwise into a one-byte hold register.
REQ-020 The shifter SHALL emit bits MSB-first, one per cycle: WR=1, DOUT=bit, for 8 consecutive cycles, with the first WR in the cycle after the INT that loaded the shifter.
REQ-021 When the shifter empties and the hold register is valid, the block SHALL load the hold byte with no gap cycle, so WR stays continuous.
REQ-022 An INT that coincides with the last shift cycle SHALL load the shifter directly, with no gap.
REQ-023 An INT that arrives while both the shifter and the hold register are full SHALL drop the byte, pulse ERR, abandon the remaining writes and return the block to IDLE with BUSY=0.
REQ-024 ADDR SHALL start at the frame start address, increment by 1 after every WR cycle, and wrap from Ncells-1 to 0.
REQ-025 After the 8th bit of the Nth payload byte, DONE SHALL pulse for one cycle, BUSY SHALL fall in the same cycle, and the state SHALL become IDLE.
REQ-026 Header bytes received in any state other than IDLE SHALL be treated as data and SHALL NOT restart the frame.
REQ-027 When WR=0, DOUT SHALL be 0.
REQ-028 INT during the DONE or ERR cycle SHALL be processed as an IDLE byte.

Reset
REQ-029 With RST_=0 at a clock edge, the block SHALL set state=IDLE, ADDR=0, WR=0, DOUT=0, BUSY=0, DONE=0 and ERR=0, and clear the shifter and hold valid flags.
REQ-030 A reset mid-frame SHALL abort the frame with no further WR and no DONE or ERR pulse.
REQ-031 INT SHALL be ignored while RST_=0.

Verification
REQ-032 Send A5 00 00 10 00 01 C3 with INT gaps of 100 cycles -> 8 WR cycles at ADDR 16..23, DOUT 1,1,0,0,0,0,1,1; DONE one cycle after the last WR.
REQ-033 Send A5 04 AF FF 00 01 FF (start address 307199) -> WR at ADDR 307199, then 0..6; no ERR.
REQ-034 Send A5 04 B0 00 00 01 (start address 307200) -> ERR pulse, zero WR cycles, BUSY=0; a following valid frame is accepted.
REQ-035 Send the N=2 payload bytes F0 and 0F on back-to-back cycles -> 16 continuous WR cycles, DOUT 11110000 00001111; then send a third byte while the shifter and hold are full -> ERR, block returns to IDLE.
REQ-036 Send 3C (ignored), then A5 00 00 00 00 00 -> no WR cycles and a DONE pulse; assert RST_=0 mid-payload in a separate frame -> WR stops the next cycle, all outputs 0.

Source files
------------

// File: rtl/pixel_loader.sv
// Purpose : parses a UART byte stream (Header, 24-bit start address, 16-bit
//           length, payload) and writes each payload bit to a 1-bit VRAM.
// Latency : first WR the cycle after the INT that delivers a payload byte.
//           Once running, the writes go out one bit per cycle.
// Backpr. : none upstream. There is one hold byte of slack. A byte that
//           arrives while the shifter and the hold byte are both full aborts
//           the frame with ERR.
// Ports   : CLK/RST_ clock and sync active-low reset. DIN/INT carry the UART
//           byte and its strobe. ADDR/WR/DOUT form the VRAM write port.
//           BUSY shows a frame in progress. DONE/ERR are completion and abort
//           pulses.
module pixel_loader #(
    parameter int         Ncells = 307200,
    parameter logic [7:0] Header = 8'hA5,
    localparam int        AW     = $clog2(Ncells)
) (
    input  logic          CLK,
    input  logic          RST_,
    input  logic [7:0]    DIN,
    input  logic          INT,
    output logic [AW-1:0] ADDR,
    output logic          WR,
    output logic          DOUT,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR
);

    typedef enum logic [2:0] {IDLE, ADR2, ADR1, ADR0, LEN1, LEN0, DATA} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(Ncells - 1);
    localparam logic [31:0]   NCELLS_W  = 32'(Ncells);

    state_t        state;
    logic [23:0]   start_adr;
    logic [7:0]    len_hi;
    logic [15:0]   bytes_left;   // payload bytes not yet accepted
    logic [7:0]    sh_dat;       // bits still to emit, MSB first
    logic [2:0]    bit_cnt;      // bits remaining after the one on DOUT
    logic [7:0]    hold_dat;
    logic          hold_vld;

    logic          sh_free;
    logic          more;
    logic [AW-1:0] addr_nxt;

    // The shifter can take a new byte when it is idle, or when DOUT shows
    // its last bit. That second case keeps back-to-back bytes gap-free.
    assign sh_free  = !WR || (bit_cnt == 3'd0);
    assign more     = INT && (bytes_left != 16'd0);
    assign addr_nxt = (ADDR == LAST_ADDR) ? '0 : ADDR + AW'(1);

    always_ff @(posedge CLK) begin
        if (!RST_) begin
            state      <= IDLE;
            ADDR       <= '0;
            WR         <= 1'b0;
            DOUT       <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            start_adr  <= '0;
            len_hi     <= '0;
            bytes_left <= '0;
            sh_dat     <= '0;
            bit_cnt    <= '0;
            hold_dat   <= '0;
            hold_vld   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                IDLE: if (INT && DIN == Header) begin
                    state <= ADR2;
                    BUSY  <= 1'b1;
                end
                ADR2: if (INT) begin
                    start_adr[23:16] <= DIN;
                    state            <= ADR1;
                end
                ADR1: if (INT) begin
                    start_adr[15:8] <= DIN;
                    state           <= ADR0;
                end
                ADR0: if (INT) begin
                    start_adr[7:0] <= DIN;
                    state          <= LEN1;
                end
                LEN1: if (INT) begin
                    len_hi <= DIN;
                    state  <= LEN0;
                end
                LEN0: if (INT) begin
                    // The range check uses the full 24-bit address, not the
                    // truncated one.
                    if ({8'h00, start_adr} >= NCELLS_W) begin
                        ERR   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else if ({len_hi, DIN} == 16'd0) begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        ADDR       <= start_adr[AW-1:0];
                        bytes_left <= {len_hi, DIN};
                        bit_cnt    <= '0;
                        hold_vld   <= 1'b0;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (WR)
                        ADDR <= addr_nxt;
                    if (INT && !sh_free && hold_vld) begin
                        // Overflow. Drop the byte and abandon the frame.
                        ERR      <= 1'b1;
                        BUSY     <= 1'b0;
                        WR       <= 1'b0;
                        DOUT     <= 1'b0;
                        hold_vld <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= IDLE;
                    end else if (!sh_free) begin
                        DOUT    <= sh_dat[7];
                        sh_dat  <= {sh_dat[6:0], 1'b0};
                        bit_cnt <= bit_cnt - 3'd1;
                        if (more) begin
                            hold_dat   <= DIN;
                            hold_vld   <= 1'b1;
                            bytes_left <= bytes_left - 16'd1;
                        end
                    end else if (hold_vld) begin
                        WR      <= 1'b1;
                        DOUT    <= hold_dat[7];
                        sh_dat  <= {hold_dat[6:0], 1'b0};
                        bit_cnt <= 3'd7;
                        // The hold register drains and refills on the same
                        // edge when a new byte coincides with the handoff.
                        if (more) begin
                            hold_dat   <= DIN;
                            bytes_left <= bytes_left - 16'd1;
                        end else begin
                            hold_vld <= 1'b0;
                        end
                    end else if (more) begin
                        WR         <= 1'b1;
                        DOUT       <= DIN[7];
                        sh_dat     <= {DIN[6:0], 1'b0};
                        bit_cnt    <= 3'd7;
                        bytes_left <= bytes_left - 16'd1;
                    end else begin
                        WR   <= 1'b0;
                        DOUT <= 1'b0;
                        if (bytes_left == 16'd0) begin
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_loader.sv
// Purpose : directed bench for pixel_loader. It runs a table of frames plus
//           hand-written reset and back-to-back-frame sequences.
// Latency : n/a.
// Backpr. : n/a. Bytes are driven as INT strobes with fixed gaps.
module tb_pixel_loader;

    localparam int NC = 307200;

    logic        CLK;
    logic        RST_;
    logic [7:0]  DIN;
    logic        INT;
    logic [18:0] ADDR;
    logic        WR;
    logic        DOUT;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    pixel_loader dut (
        .CLK  (CLK),
        .RST_ (RST_),
        .DIN  (DIN),
        .INT  (INT),
        .ADDR (ADDR),
        .WR   (WR),
        .DOUT (DOUT),
        .BUSY (BUSY),
        .DONE (DONE),
        .ERR  (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Write log, filled only by the monitor. The tests read it through
    // base offsets.
    int cyc = 0;
    int wr_addr[$];
    bit wr_bit[$];
    int wr_cyc[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int err_cnt = 0;
    int dout_viol = 0;

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (WR) begin
            wr_addr.push_back(int'(ADDR));
            wr_bit.push_back(DOUT);
            wr_cyc.push_back(cyc);
        end
        if (DONE) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (ERR)
            err_cnt <= err_cnt + 1;
        if (!WR && DOUT)
            dout_viol <= dout_viol + 1;
    end

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        DIN = b;
        INT = 1'b1;
        tick();
        INT = 1'b0;
        DIN = 8'h00;
    endtask

    typedef struct {
        int          n;        // bytes to send
        logic [71:0] b;        // bytes, first one in the top byte
        int          gap;      // idle cycles between bytes
        int          exp_wr;
        int          addr0;
        logic [15:0] bits;     // expected DOUT sequence, first bit at [15]
        int          exp_done;
        int          exp_err;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [71:0] b, input int gap,
                                input int wr, input int a0, input logic [15:0] bits,
                                input int d, input int e);
        vec_t v;
        v.n = n; v.b = b; v.gap = gap; v.exp_wr = wr; v.addr0 = a0;
        v.bits = bits; v.exp_done = d; v.exp_err = e;
        return v;
    endfunction

    task automatic run_vec(input int k, input vec_t v);
        int wb, db, eb, n;
        wb = wr_addr.size();
        db = done_cnt;
        eb = err_cnt;
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.b[71-8*i -: 8]);
            if (i < v.n - 1)
                repeat (v.gap) tick();
        end
        repeat (30) tick();
        n = wr_addr.size() - wb;
        chk($sformatf("v%0d_wr_count", k), n, v.exp_wr);
        for (int i = 0; i < n && i < v.exp_wr; i++) begin
            chk($sformatf("v%0d_addr%0d", k, i), wr_addr[wb+i], (v.addr0 + i) % NC);
            chk($sformatf("v%0d_bit%0d", k, i), int'(wr_bit[wb+i]), int'(v.bits[15-i]));
        end
        if (n > 0 && n == v.exp_wr)
            chk($sformatf("v%0d_wr_contig", k), wr_cyc[wb+n-1] - wr_cyc[wb], n - 1);
        chk($sformatf("v%0d_done", k), done_cnt - db, v.exp_done);
        chk($sformatf("v%0d_err", k), err_cnt - eb, v.exp_err);
        chk($sformatf("v%0d_busy_end", k), int'(BUSY), 0);
        if (v.exp_done != 0 && n > 0)
            chk($sformatf("v%0d_done_after_wr", k), done_cyc, wr_cyc[wb+n-1] + 1);
    endtask

    vec_t tbl[8];

    initial begin
        int wb, db, eb;

        tbl[0] = mk(7, 72'hA5_00_00_10_00_01_C3_00_00, 100, 8,     16, 16'hC300, 1, 0);
        tbl[1] = mk(7, 72'hA5_04_AF_FF_00_01_FF_00_00,   2, 8, 307199, 16'hFF00, 1, 0);
        tbl[2] = mk(6, 72'hA5_04_B0_00_00_01_00_00_00,   1, 0,      0, 16'h0000, 0, 1);
        tbl[3] = mk(7, 72'hA5_00_00_20_00_01_5A_00_00,   0, 8,     32, 16'h5A00, 1, 0);
        tbl[4] = mk(8, 72'hA5_00_01_00_00_02_F0_0F_00,   0, 16,   256, 16'hF00F, 1, 0);
        tbl[5] = mk(9, 72'hA5_00_00_40_00_03_11_22_33,   0, 2,     64, 16'h0000, 0, 1);
        tbl[6] = mk(7, 72'h3C_A5_00_00_00_00_00_00_00,   3, 0,      0, 16'h0000, 1, 0);
        tbl[7] = mk(7, 72'hA5_00_00_08_00_01_A5_00_00,   5, 8,      8, 16'hA500, 1, 0);

        // Reset with a header strobe present, which must be ignored.
        RST_ = 1'b0;
        INT  = 1'b1;
        DIN  = 8'hA5;
        repeat (3) tick();
        chk("rst_addr", int'(ADDR), 0);
        chk("rst_wr",   int'(WR),   0);
        chk("rst_dout", int'(DOUT), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_err",  int'(ERR),  0);
        RST_ = 1'b1;
        INT  = 1'b0;
        DIN  = 8'h00;
        tick();
        chk("rst_int_ignored", int'(BUSY), 0);

        for (int k = 0; k < 8; k++)
            run_vec(k, tbl[k]);

        // Reset in the middle of a payload byte.
        wb = wr_addr.size();
        db = done_cnt;
        eb = err_cnt;
        send_byte(8'hA5);
        chk("busy_after_hdr", int'(BUSY), 1);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hAA);
        repeat (3) tick();
        chk("wr_before_rst", int'(WR), 1);
        RST_ = 1'b0;
        tick();
        chk("midrst_wr",   int'(WR),   0);
        chk("midrst_dout", int'(DOUT), 0);
        chk("midrst_addr", int'(ADDR), 0);
        chk("midrst_busy", int'(BUSY), 0);
        RST_ = 1'b1;
        repeat (20) tick();
        chk("midrst_wr_count", wr_addr.size() - wb, 4);
        chk("midrst_no_done", done_cnt - db, 0);
        chk("midrst_no_err",  err_cnt - eb, 0);

        // A header arriving in the DONE cycle starts the next frame.
        db = done_cnt;
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) send_byte(8'h00);
        chk("done_pulse", int'(DONE), 1);
        send_byte(8'hA5);
        chk("hdr_in_done_cycle", int'(BUSY), 1);
        for (int i = 0; i < 5; i++) send_byte(8'h00);
        tick();
        chk("two_frames_done", done_cnt - db, 2);
        chk("two_frames_busy", int'(BUSY), 0);

        chk("dout_zero_when_no_wr", dout_viol, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
